// File: rtl/nrzi_stuff_tx.sv
// Transmit line encoder: SYNC prefix, bit stuffing after runs of ones,
// NRZI encoding and an SE0/J end-of-packet, one line symbol per cycle.
module nrzi_stuff_tx #(
  parameter int STUFF_LEN = 6,
  parameter int SYNC_BITS = 8,
  parameter int EOP_SE0   = 2,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             line_out,
  output logic             out_se0,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] stuff_cnt
);

  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int SW = $clog2(SYNC_BITS + 1);
  localparam int EW = $clog2(EOP_SE0 + 1);

  localparam logic [OW-1:0] ONES_STUFF = OW'(STUFF_LEN);
  localparam logic [SW-1:0] SYNC_LAST  = SW'(SYNC_BITS - 1);
  localparam logic [EW-1:0] EOP_LAST   = EW'(EOP_SE0 - 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP, EOPJ} state_t;

  state_t           state, state_d;
  logic [OW-1:0]    ones_cnt, ones_d, ones_inc;
  logic [SW-1:0]    sync_cnt, sync_d;
  logic [EW-1:0]    eop_cnt, eop_d;
  logic             last_q, last_d;
  logic             line_d, se0_d, valid_d, busy_d, done_d;
  logic [CNT_W-1:0] stuff_cnt_d;

  // Only the state decides whether a bit is taken; no combinational path from in_valid.
  assign in_ready = (state == DATA);

  // NOTE: every signal gets a default before the case so no path can leave it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d     = state;
    ones_d      = ones_cnt;
    sync_d      = sync_cnt;
    eop_d       = eop_cnt;
    last_d      = last_q;
    line_d      = line_out;
    se0_d       = 1'b0;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    stuff_cnt_d = stuff_cnt;
    ones_inc    = in_bit ? ones_cnt + OW'(1) : '0;

    case (state)
      IDLE: begin
        line_d = 1'b1;
        if (in_valid) begin
          state_d     = SYNC;
          sync_d      = '0;
          ones_d      = '0;
          stuff_cnt_d = '0;
        end
      end

      SYNC: begin
        valid_d = 1'b1;
        if (sync_cnt == SYNC_LAST) begin
          // The closing SYNC one starts the run that stuffing watches.
          ones_d  = OW'(1);
          sync_d  = '0;
          state_d = DATA;
        end else begin
          line_d = ~line_out;
          sync_d = sync_cnt + SW'(1);
        end
      end

      DATA: begin
        if (in_valid) begin
          valid_d = 1'b1;
          last_d  = in_last;
          ones_d  = ones_inc;
          line_d  = in_bit ? line_out : ~line_out;
          if (ones_inc == ONES_STUFF) begin
            state_d = STUFF;
          end else if (in_last) begin
            state_d = EOP;
            eop_d   = '0;
          end
        end
      end

      STUFF: begin
        valid_d = 1'b1;
        line_d  = ~line_out;
        ones_d  = '0;
        if (stuff_cnt != '1) stuff_cnt_d = stuff_cnt + CNT_W'(1);
        if (last_q) begin
          state_d = EOP;
          eop_d   = '0;
        end else begin
          state_d = DATA;
        end
      end

      EOP: begin
        valid_d = 1'b1;
        se0_d   = 1'b1;
        line_d  = 1'b0;
        if (eop_cnt == EOP_LAST) state_d = EOPJ;
        else                     eop_d   = eop_cnt + EW'(1);
      end

      EOPJ: begin
        valid_d = 1'b1;
        line_d  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ones_cnt  <= '0;
      sync_cnt  <= '0;
      eop_cnt   <= '0;
      last_q    <= 1'b0;
      line_out  <= 1'b1;
      out_se0   <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stuff_cnt <= '0;
    end else begin
      state     <= state_d;
      ones_cnt  <= ones_d;
      sync_cnt  <= sync_d;
      eop_cnt   <= eop_d;
      last_q    <= last_d;
      line_out  <= line_d;
      out_se0   <= se0_d;
      out_valid <= valid_d;
      busy      <= busy_d;
      done      <= done_d;
      stuff_cnt <= stuff_cnt_d;
    end
  end

endmodule

// File: tb/tb_nrzi_stuff_tx.sv
// Bench for nrzi_stuff_tx: directed vector table plus randomized packets
// compared symbol-by-symbol against a stream-level model of the line code.
module tb_nrzi_stuff_tx;

  localparam int STUFF_LEN = 6;
  localparam int SYNC_BITS = 8;
  localparam int EOP_SE0   = 2;
  localparam int CNT_W     = 6;
  localparam int MAX_CNT   = (1 << CNT_W) - 1;
  localparam int SYM_SE0   = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready, line_out, out_se0, out_valid, busy, done;
  logic [CNT_W-1:0] stuff_cnt;

  nrzi_stuff_tx #(
    .STUFF_LEN(STUFF_LEN), .SYNC_BITS(SYNC_BITS), .EOP_SE0(EOP_SE0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_bit(in_bit), .in_last(in_last), .line_out(line_out), .out_se0(out_se0),
    .out_valid(out_valid), .busy(busy), .done(done), .stuff_cnt(stuff_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_str(input string name, input string got, input string exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %s expected %s", name, got, exp);
    end
  endtask

  // Packet under test, model output and captured output
  logic pkt_bits[$];
  int   exp_syms[$];
  int   got_syms[$];
  int   exp_stuff;

  // Results of the last run_packet call
  int               n_done, rdy_low, gaps, gap_bad, timed_out;
  logic [CNT_W-1:0] got_stuff;

  // Model: raw bit stream = SYNC then data; a zero is inserted after every
  // STUFF_LEN consecutive ones; zero toggles the line, one holds it.
  logic m_lvl;
  int   m_run;

  function automatic void model_bit(input logic b);
    if (!b) m_lvl = ~m_lvl;
    exp_syms.push_back(int'(m_lvl));
    m_run = b ? m_run + 1 : 0;
  endfunction

  function automatic void build_expected();
    int stuffs;
    stuffs = 0;
    m_lvl  = 1'b1;
    m_run  = 0;
    exp_syms.delete();
    for (int i = 0; i < SYNC_BITS; i++) model_bit(i == SYNC_BITS - 1);
    foreach (pkt_bits[i]) begin
      model_bit(pkt_bits[i]);
      if (m_run == STUFF_LEN) begin
        model_bit(1'b0);
        stuffs++;
      end
    end
    for (int i = 0; i < EOP_SE0; i++) exp_syms.push_back(SYM_SE0);
    exp_syms.push_back(1);
    exp_stuff = (stuffs > MAX_CNT) ? MAX_CNT : stuffs;
  endfunction

  // Drives one packet and records everything seen on the outputs.
  // rst_at >= 0 asserts rst once that many bits were accepted and returns
  // one cycle later with rst still high.
  task automatic run_packet(input int stall_at, input int stall_len,
                            input int stall_pct, input int rst_at);
    int   idx, stall_left, cyc;
    bit   acc, seen_rdy;
    logic prev_line;
    idx = 0; stall_left = stall_len; cyc = 0; acc = 0; seen_rdy = 0; prev_line = 1'b1;
    got_syms.delete();
    n_done = 0; rdy_low = 0; gaps = 0; gap_bad = 0; timed_out = 0; got_stuff = '0;
    forever begin
      @(negedge clk);
      if (acc) idx++;
      if (out_valid) begin
        got_syms.push_back(out_se0 ? SYM_SE0 : int'(line_out));
        if (!out_se0) prev_line = line_out;
      end else if (busy) begin
        gaps++;
        if (line_out !== prev_line) gap_bad++;
      end
      if (done) begin
        n_done++;
        got_stuff = stuff_cnt;
        break;
      end
      if (in_ready) seen_rdy = 1;
      else if (seen_rdy) rdy_low++;
      if (rst_at >= 0 && idx == rst_at) begin
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        return;
      end
      if (idx >= pkt_bits.size()) begin
        in_valid = 1'b0;
      end else if (idx == stall_at && stall_left > 0) begin
        in_valid = 1'b0;
        stall_left--;
      end else if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_bit   = pkt_bits[idx];
        in_last  = (idx == pkt_bits.size() - 1);
      end
      acc = in_valid && in_ready;
      cyc++;
      if (cyc > 5000) begin
        timed_out = 1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic compare_model(input string tag);
    int mism;
    mism = 0;
    check({tag, "_timeout"}, timed_out, 0);
    check({tag, "_sym_count"}, got_syms.size(), exp_syms.size());
    foreach (exp_syms[i]) begin
      if (i >= got_syms.size() || got_syms[i] != exp_syms[i]) mism++;
    end
    check({tag, "_sym_mismatches"}, mism, 0);
    check({tag, "_stuff_cnt"}, got_stuff, exp_stuff);
    check({tag, "_done_pulses"}, n_done, 1);
    check({tag, "_gap_line_moved"}, gap_bad, 0);
  endtask

  typedef struct {
    string       name;
    logic [15:0] data;       // bit i is the i-th data bit sent
    int          len;
    int          stall_at;
    int          stall_len;
    string       exp_line;   // line levels of SYNC + data + stuff symbols
    int          exp_valid;
    int          exp_stuff;
    int          exp_rdy_low;
    int          exp_gaps;
  } vec_t;

  vec_t vecs[4];

  task automatic run_vec(input int v);
    string s;
    pkt_bits.delete();
    for (int i = 0; i < vecs[v].len; i++) pkt_bits.push_back(vecs[v].data[i]);
    build_expected();
    run_packet(vecs[v].stall_at, vecs[v].stall_len, 0, -1);
    s = "";
    for (int i = 0; i < vecs[v].exp_line.len() && i < got_syms.size(); i++)
      s = {s, (got_syms[i] == SYM_SE0) ? "S" : (got_syms[i] == 1 ? "1" : "0")};
    check_str({vecs[v].name, "_line"}, s, vecs[v].exp_line);
    check({vecs[v].name, "_valid_cycles"}, got_syms.size(), vecs[v].exp_valid);
    check({vecs[v].name, "_stuff_exp"}, got_stuff, vecs[v].exp_stuff);
    check({vecs[v].name, "_ready_low"}, rdy_low, vecs[v].exp_rdy_low);
    check({vecs[v].name, "_gaps"}, gaps, vecs[v].exp_gaps);
    compare_model(vecs[v].name);
  endtask

  initial begin
    vecs[0] = '{"byte00", 16'h0000, 8, -1, 0, "0101010010101010", 19, 0, 3, 1};
    vecs[1] = '{"byteff", 16'h00FF, 8, -1, 0, "01010100000001111", 20, 1, 4, 1};
    vecs[2] = '{"ones11", 16'h07FF, 11, -1, 0, "010101000000011111110", 24, 2, 5, 1};
    vecs[3] = '{"ff_stall", 16'h00FF, 8, 3, 3, "01010100000001111", 20, 1, 4, 4};

    // Reset held with in_valid high must keep the block idle.
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_line_out", line_out, 1'b1);
    check("rst_out_se0", out_se0, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_stuff_cnt", stuff_cnt, 0);
    in_valid = 1'b0;
    rst = 1'b0;

    for (int v = 0; v < 4; v++) run_vec(v);

    // Reset during DATA after four accepted bits.
    pkt_bits.delete();
    for (int i = 0; i < 8; i++) pkt_bits.push_back(1'b0);
    run_packet(-1, 0, 0, 4);
    check("midrst_line_out", line_out, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_done_after", done, 1'b0);
    check("midrst_idle_after", busy, 1'b0);
    run_vec(0);

    // Randomized packets with random upstream stalls.
    for (int p = 0; p < 25; p++) begin
      int len;
      len = $urandom_range(40, 1);
      pkt_bits.delete();
      for (int i = 0; i < len; i++) pkt_bits.push_back($urandom_range(99) < 75);
      build_expected();
      run_packet(-1, 0, $urandom_range(30), -1);
      compare_model($sformatf("rand%0d", p));
    end

    // Long run of ones drives the stuff counter into saturation.
    pkt_bits.delete();
    for (int i = 0; i < 400; i++) pkt_bits.push_back(1'b1);
    build_expected();
    run_packet(-1, 0, 0, -1);
    compare_model("saturate");
    check("saturate_all_ones", got_stuff, MAX_CNT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
